// File: rtl/pkt_hdr_checker_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pkt_hdr_checker_pkg
// Purpose  : Shared types and constants for the packet header checker.
//            Provides the FSM state type, error bit positions, and the
//            protocol constants used for the header checks.
// Revision : 1.0  initial release
// ============================================================================
package pkt_hdr_checker_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        HDR     = 2'd1,
        PAYLOAD = 2'd2,
        VERDICT = 2'd3
    } state_t;

    // Bit positions inside err_code
    localparam int ERR_HDR  = 0;
    localparam int ERR_CSUM = 1;
    localparam int ERR_ADDR = 2;
    localparam int ERR_LEN  = 3;

    localparam logic [15:0] ETHERTYPE_IP    = 16'h0800;
    localparam logic [7:0]  IP_PROTO_UDP    = 8'd17;
    localparam logic [7:0]  MODULE_HDR_CTRL = 8'hFF;
    localparam logic [7:0]  IP_VER_IHL      = 8'h45;   // IPv4, 20-byte header
    localparam logic [15:0] ETH_HDR_BYTES   = 16'd14;
    localparam logic [15:0] HDR_WORDS       = 16'd6;   // header words after module header

endpackage
`default_nettype wire

// File: rtl/pkt_hdr_checker_csum.sv
`default_nettype none
// ============================================================================
// Module   : ip_csum_accum
// Purpose  : Ones'-complement accumulator for the IPv4 header checksum.
//            Up to four 16-bit lanes of add_data can be added per cycle
//            (lane i = add_data[16*i+15:16*i], enabled by add_en[i]).
//            The 20-bit raw sum is folded with end-around carries; is_ffff
//            flags a header whose checksum verifies.
// Ports    : clk, reset (sync, active-high), clear, add_en[3:0],
//            add_data[63:0], is_ffff
// Revision : 1.0  initial release
// ============================================================================
module ip_csum_accum (
    input  logic        clk,
    input  logic        reset,
    input  logic        clear,
    input  logic [3:0]  add_en,
    input  logic [63:0] add_data,
    output logic        is_ffff
);

    logic [19:0] acc;
    logic [19:0] addend;
    logic [16:0] fold1;
    logic [15:0] fold2;

    always_comb begin
        addend = '0;
        for (int i = 0; i < 4; i++) begin
            if (add_en[i]) begin
                addend = addend + {4'd0, add_data[16*i +: 16]};
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            acc <= '0;
        end else if (|add_en) begin
            acc <= acc + addend;
        end
    end

    // Ten halfwords fit in 20 bits, so two fold stages absorb every carry:
    // the first can produce at most one new carry, the second absorbs it.
    assign fold1   = {1'b0, acc[15:0]} + {13'd0, acc[19:16]};
    assign fold2   = fold1[15:0] + {15'd0, fold1[16]};
    assign is_ffff = (fold2 == 16'hFFFF);

endmodule
`default_nettype wire

// File: rtl/pkt_hdr_checker.sv
`default_nettype none
// ============================================================================
// Module   : pkt_hdr_checker
// Purpose  : Sink that inspects Ethernet/IPv4/UDP packets framed by a module
//            header word (ctrl=0xFF) and reports a one-cycle good/bad verdict
//            per packet, with running good/bad counters.
// Ports    : clk, reset (sync, active-high)
//            in_data, in_ctrl, in_wr, in_rdy (always 1)
//            exp_dst_ip, exp_udp_dst_port
//            pkt_ok, pkt_err, err_code, num_pkts_ok, num_pkts_err
// Config   : PKT_HDR_CHECKER_STRICT_LEN_EN -- when defined, the word count
//            from the module header (word_len) must match the number of words
//            received up to and including EOP.
// Revision : 1.0  initial release
// ============================================================================
module pkt_hdr_checker
    import pkt_hdr_checker_pkg::*;
#(
    parameter int DATA_WIDTH = 64,
    parameter int CTRL_WIDTH = DATA_WIDTH / 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic [CTRL_WIDTH-1:0] in_ctrl,
    input  logic                  in_wr,
    output logic                  in_rdy,
    input  logic [31:0]           exp_dst_ip,
    input  logic [15:0]           exp_udp_dst_port,
    output logic                  pkt_ok,
    output logic                  pkt_err,
    output logic [3:0]            err_code,
    output logic [31:0]           num_pkts_ok,
    output logic [31:0]           num_pkts_err
);

    localparam logic [CTRL_WIDTH-1:0] CTRL_MOD_HDR = CTRL_WIDTH'(MODULE_HDR_CTRL);

    state_t      state, state_next;
    logic [15:0] byte_len;
    logic [15:0] word_cnt;       // words accepted since the module header
    logic [15:0] hdr_idx;        // 1-based index of the word on the bus
    logic [15:0] dst_ip_hi;      // dst IP upper half, carried from word 4
    logic [3:0]  err_bits;
    logic [3:0]  word_err;
    logic [3:0]  verdict_err;
    logic        verdict_fire;
    logic [31:0] ok_count;
    logic [31:0] err_count;
    logic        is_mod_hdr;
    logic        ctrl_zero;
    logic        in_pkt;
    logic        hdr_word;
    logic [3:0]  csum_add_en;
    logic        csum_ok;
    logic        len_words_bad;

    assign in_rdy       = 1'b1;
    assign num_pkts_ok  = ok_count;
    assign num_pkts_err = err_count;

    assign is_mod_hdr = in_wr && (in_ctrl == CTRL_MOD_HDR);
    assign ctrl_zero  = (in_ctrl == '0);
    assign in_pkt     = (state == HDR) || (state == PAYLOAD);
    assign hdr_word   = in_wr && ctrl_zero && (state == HDR);
    assign hdr_idx    = word_cnt + 16'd1;

`ifdef PKT_HDR_CHECKER_STRICT_LEN_EN
    logic [15:0] word_len;

    always_ff @(posedge clk) begin
        if (reset) begin
            word_len <= '0;
        end else if (is_mod_hdr) begin
            word_len <= in_data[47:32];
        end
    end

    // Evaluated on the EOP word itself, hence the +1
    assign len_words_bad = (hdr_idx != word_len);
`else
    assign len_words_bad = 1'b0;
`endif

    // Per-word header field checks and checksum lane selection
    always_comb begin
        word_err    = '0;
        csum_add_en = '0;
        if (hdr_word) begin
            case (hdr_idx)
                16'd2: begin
                    if ((in_data[31:16] != ETHERTYPE_IP) || (in_data[15:8] != IP_VER_IHL)) begin
                        word_err[ERR_HDR] = 1'b1;
                    end
                    csum_add_en = 4'b0001;
                end
                16'd3: begin
                    if (in_data[7:0] != IP_PROTO_UDP) begin
                        word_err[ERR_HDR] = 1'b1;
                    end
                    if (byte_len != (in_data[63:48] + ETH_HDR_BYTES)) begin
                        word_err[ERR_LEN] = 1'b1;
                    end
                    csum_add_en = 4'b1111;
                end
                16'd4: begin
                    csum_add_en = 4'b1111;
                end
                16'd5: begin
                    if (({dst_ip_hi, in_data[63:48]} != exp_dst_ip) ||
                        (in_data[31:16] != exp_udp_dst_port)) begin
                        word_err[ERR_ADDR] = 1'b1;
                    end
                    csum_add_en = 4'b1000;
                end
                default: ;
            endcase
        end
    end

    ip_csum_accum u_csum (
        .clk      (clk),
        .reset    (reset),
        .clear    (is_mod_hdr),
        .add_en   (csum_add_en),
        .add_data (in_data[63:0]),
        .is_ffff  (csum_ok)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // A module header word starts a new packet from any state; inside a
    // packet it also aborts the old one, so the FSM stays in HDR while the
    // abort verdict is issued alongside.
    always_comb begin
        state_next   = state;
        verdict_fire = 1'b0;
        verdict_err  = '0;
        case (state)
            IDLE, VERDICT: begin
                state_next = is_mod_hdr ? HDR : IDLE;
            end
            HDR: begin
                if (in_wr) begin
                    if (is_mod_hdr) begin
                        state_next           = HDR;
                        verdict_fire         = 1'b1;
                        verdict_err          = err_bits;
                        verdict_err[ERR_LEN] = 1'b1;
                    end else if (!ctrl_zero) begin
                        state_next           = VERDICT;
                        verdict_fire         = 1'b1;
                        verdict_err          = err_bits;
                        verdict_err[ERR_LEN] = 1'b1;
                    end else if (hdr_idx == HDR_WORDS) begin
                        state_next = PAYLOAD;
                    end
                end
            end
            PAYLOAD: begin
                if (in_wr) begin
                    if (is_mod_hdr) begin
                        state_next           = HDR;
                        verdict_fire         = 1'b1;
                        verdict_err          = err_bits;
                        verdict_err[ERR_LEN] = 1'b1;
                    end else if (!ctrl_zero) begin
                        state_next   = VERDICT;
                        verdict_fire = 1'b1;
                        verdict_err  = err_bits;
                        if (!csum_ok) begin
                            verdict_err[ERR_CSUM] = 1'b1;
                        end
                        if (len_words_bad) begin
                            verdict_err[ERR_LEN] = 1'b1;
                        end
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Verdict outputs are registered so they appear in the cycle after the
    // terminating word, which is the VERDICT cycle for a normal EOP.
    always_ff @(posedge clk) begin
        if (reset) begin
            byte_len  <= '0;
            word_cnt  <= '0;
            dst_ip_hi <= '0;
            err_bits  <= '0;
            pkt_ok    <= 1'b0;
            pkt_err   <= 1'b0;
            err_code  <= '0;
            ok_count  <= '0;
            err_count <= '0;
        end else begin
            pkt_ok  <= verdict_fire && (verdict_err == 4'd0);
            pkt_err <= verdict_fire && (verdict_err != 4'd0);
            if (verdict_fire) begin
                if (verdict_err == 4'd0) begin
                    ok_count <= ok_count + 32'd1;
                end else begin
                    err_count <= err_count + 32'd1;
                    err_code  <= verdict_err;
                end
            end

            if (is_mod_hdr) begin
                byte_len  <= in_data[15:0];
                word_cnt  <= '0;
                dst_ip_hi <= '0;
                err_bits  <= '0;
            end else if (in_wr && in_pkt) begin
                word_cnt <= word_cnt + 16'd1;
                if (hdr_word) begin
                    err_bits <= err_bits | word_err;
                    if (hdr_idx == 16'd4) begin
                        dst_ip_hi <= in_data[15:0];
                    end
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_pkt_hdr_checker.sv
`default_nettype none
// ============================================================================
// Module   : tb_pkt_hdr_checker
// Purpose  : Self-checking bench for pkt_hdr_checker. Directed packets push
//            their expected verdict (kind, err_code, sample time) into a
//            queue; a monitor pops and compares on every verdict pulse.
//            Honors PKT_HDR_CHECKER_STRICT_LEN_EN for the short-packet case.
// Revision : 1.0  initial release
// ============================================================================
module tb_pkt_hdr_checker;

    logic        clk = 1'b0;
    logic        reset;
    logic [63:0] in_data;
    logic [7:0]  in_ctrl;
    logic        in_wr;
    logic        in_rdy;
    logic [31:0] exp_dst_ip;
    logic [15:0] exp_udp_dst_port;
    logic        pkt_ok;
    logic        pkt_err;
    logic [3:0]  err_code;
    logic [31:0] num_pkts_ok;
    logic [31:0] num_pkts_err;

    always #5 clk = ~clk;

    pkt_hdr_checker #(.DATA_WIDTH(64), .CTRL_WIDTH(8)) dut (
        .clk              (clk),
        .reset            (reset),
        .in_data          (in_data),
        .in_ctrl          (in_ctrl),
        .in_wr            (in_wr),
        .in_rdy           (in_rdy),
        .exp_dst_ip       (exp_dst_ip),
        .exp_udp_dst_port (exp_udp_dst_port),
        .pkt_ok           (pkt_ok),
        .pkt_err          (pkt_err),
        .err_code         (err_code),
        .num_pkts_ok      (num_pkts_ok),
        .num_pkts_err     (num_pkts_err)
    );

    typedef struct {
        logic        is_ok;
        logic [3:0]  code;
        longint      t;
    } exp_t;

    exp_t        sb_q[$];
    int          n_cmp  = 0;
    int          n_fail = 0;
    logic [31:0] exp_ok  = 32'd0;
    logic [31:0] exp_err = 32'd0;
    logic [3:0]  exp_code = 4'd0;
    logic [15:0] pk_etype = 16'h0800;
    logic [15:0] pk_port  = 16'h1234;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_cmp++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Monitor: every verdict pulse is matched against the queue head
    always @(negedge clk) begin
        if (pkt_ok === 1'b1 || pkt_err === 1'b1) begin
            check("ok_err_exclusive", {63'd0, pkt_ok & pkt_err}, 64'd0);
            if (sb_q.size() == 0) begin
                check("unexpected_pulse", {63'd0, pkt_ok}, {63'd0, pkt_err});
                check("unexpected_pulse_any", 64'd1, 64'd0 + {63'd0, (pkt_ok | pkt_err) & 1'b0});
            end else begin : pop
                exp_t e;
                e = sb_q.pop_front();
                check("verdict_kind", {63'd0, pkt_ok}, {63'd0, e.is_ok});
                if (!e.is_ok) begin
                    check("verdict_err_code", {60'd0, err_code}, {60'd0, e.code});
                end
                check("verdict_time", $time, e.t);
            end
        end
    end

    task automatic send(input logic [7:0] c, input logic [63:0] d);
        @(negedge clk);
        in_ctrl = c;
        in_data = d;
        in_wr   = 1'b1;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            in_wr   = 1'b0;
            in_ctrl = 8'h00;
            in_data = 64'd0;
        end
    endtask

    // Called right after the word that ends a packet is driven
    task automatic expect_verdict(input logic ok, input logic [3:0] code);
        exp_t e;
        e.is_ok = ok;
        e.code  = code;
        e.t     = $time + 10;
        sb_q.push_back(e);
        if (ok) begin
            exp_ok = exp_ok + 32'd1;
        end else begin
            exp_err  = exp_err + 32'd1;
            exp_code = code;
        end
    endtask

    function automatic logic [63:0] hdr_w(input int i, input logic [31:0] dip, input logic [15:0] csum);
        case (i)
            1:       return 64'h0011_2233_4455_6677;
            2:       return {32'h8899_AABB, pk_etype, 8'h45, 8'h00};
            3:       return {16'h0062, 16'h0001, 16'h0000, 8'h64, 8'h11};
            4:       return {csum, 32'hC0A8_0001, dip[31:16]};
            5:       return {dip[15:0], 16'h5000, pk_port, 16'h004E};
            default: return 64'h0000_DEAD_BEEF_0000;
        endcase
    endfunction

    task automatic send_pkt(input logic [31:0] dip, input logic [15:0] csum, input logic [15:0] blen,
                            input int npay, input bit gaps, input bit abort_prev,
                            input logic ok, input logic [3:0] code);
        send(8'hFF, {16'h0, 16'd14, 16'h0, blen});
        if (abort_prev) expect_verdict(1'b0, 4'h8);
        for (int i = 1; i <= 6; i++) begin
            if (gaps) idle(1);
            send(8'h00, hdr_w(i, dip, csum));
        end
        for (int p = 1; p <= npay; p++) begin
            send((p == npay) ? 8'h01 : 8'h00, {32'hCAFE_0000, p[31:0]});
        end
        expect_verdict(ok, code);
        idle(3);
    endtask

    task automatic check_counters(input string tag);
        check({tag, "_num_ok"},   {32'd0, num_pkts_ok},  {32'd0, exp_ok});
        check({tag, "_num_err"},  {32'd0, num_pkts_err}, {32'd0, exp_err});
        check({tag, "_err_code"}, {60'd0, err_code},     {60'd0, exp_code});
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout, want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset            = 1'b1;
        in_wr            = 1'b0;
        in_ctrl          = 8'h00;
        in_data          = 64'd0;
        exp_dst_ip       = 32'hC0A8_0002;
        exp_udp_dst_port = 16'h1234;

        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_in_rdy",  {63'd0, in_rdy},  64'd1);
        check("rst_pkt_ok",  {63'd0, pkt_ok},  64'd0);
        check("rst_pkt_err", {63'd0, pkt_err}, 64'd0);
        check_counters("rst");
        reset = 1'b0;

        // Stray words in IDLE, and a header-looking word with in_wr low
        send(8'h00, 64'h1111_2222_3333_4444);
        send(8'h01, 64'h5555_6666_7777_8888);
        @(negedge clk);
        in_wr   = 1'b0;
        in_ctrl = 8'hFF;
        in_data = {16'h0, 16'd14, 16'h0, 16'h0070};
        idle(2);

        // Good packet
        send_pkt(32'hC0A8_0002, 16'hD536, 16'h0070, 8, 1'b0, 1'b0, 1'b1, 4'h0);
        check_counters("good");

        // Bad checksum
        send_pkt(32'hC0A8_0002, 16'hD537, 16'h0070, 8, 1'b0, 1'b0, 1'b0, 4'h2);
        check_counters("bad_csum");

        // Wrong dst IP, checksum recomputed
        send_pkt(32'hC0A8_0003, 16'hD535, 16'h0070, 8, 1'b0, 1'b0, 1'b0, 4'h4);
        check_counters("bad_dst");

        // Wrong dst IP with stale checksum: both bits
        send_pkt(32'hC0A8_0003, 16'hD536, 16'h0070, 8, 1'b0, 1'b0, 1'b0, 4'h6);

        // Good packet with idle gaps between words
        send_pkt(32'hC0A8_0002, 16'hD536, 16'h0070, 8, 1'b1, 1'b0, 1'b1, 4'h0);
        check_counters("gaps");

        // Aborted by a new module header after 3 header words, then good
        send(8'hFF, {16'h0, 16'd14, 16'h0, 16'h0070});
        for (int i = 1; i <= 3; i++) send(8'h00, hdr_w(i, 32'hC0A8_0002, 16'hD536));
        send_pkt(32'hC0A8_0002, 16'hD536, 16'h0070, 8, 1'b0, 1'b1, 1'b1, 4'h0);
        check_counters("abort");

        // Runt: nonzero ctrl on header word 3
        send(8'hFF, {16'h0, 16'd14, 16'h0, 16'h0070});
        send(8'h00, hdr_w(1, 32'hC0A8_0002, 16'hD536));
        send(8'h00, hdr_w(2, 32'hC0A8_0002, 16'hD536));
        send(8'h01, hdr_w(3, 32'hC0A8_0002, 16'hD536));
        expect_verdict(1'b0, 4'h8);
        idle(3);
        check_counters("runt");

        // Length mismatch against IP total length
        send_pkt(32'hC0A8_0002, 16'hD536, 16'h0071, 8, 1'b0, 1'b0, 1'b0, 4'h8);

        // Bad ethertype
        pk_etype = 16'h86DD;
        send_pkt(32'hC0A8_0002, 16'hD536, 16'h0070, 8, 1'b0, 1'b0, 1'b0, 4'h1);
        pk_etype = 16'h0800;

        // Wrong UDP destination port
        pk_port = 16'h1235;
        send_pkt(32'hC0A8_0002, 16'hD536, 16'h0070, 8, 1'b0, 1'b0, 1'b0, 4'h4);
        pk_port = 16'h1234;
        check_counters("port");

        // 13 words instead of 14
`ifdef PKT_HDR_CHECKER_STRICT_LEN_EN
        send_pkt(32'hC0A8_0002, 16'hD536, 16'h0070, 7, 1'b0, 1'b0, 1'b0, 4'h8);
`else
        send_pkt(32'hC0A8_0002, 16'hD536, 16'h0070, 7, 1'b0, 1'b0, 1'b1, 4'h0);
`endif
        check_counters("short");

        // Reset mid-packet: no verdict, everything cleared
        send(8'hFF, {16'h0, 16'd14, 16'h0, 16'h0070});
        send(8'h00, hdr_w(1, 32'hC0A8_0002, 16'hD536));
        send(8'h00, hdr_w(2, 32'hC0A8_0002, 16'hD536));
        @(negedge clk);
        in_wr = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        reset    = 1'b0;
        exp_ok   = 32'd0;
        exp_err  = 32'd0;
        exp_code = 4'd0;
        idle(2);
        check_counters("mid_reset");
        send_pkt(32'hC0A8_0002, 16'hD536, 16'h0070, 8, 1'b0, 1'b0, 1'b1, 4'h0);
        check_counters("after_reset");

        // Good counter wraps from all-ones to zero
        @(negedge clk);
        force dut.ok_count = 32'hFFFF_FFFF;
        @(negedge clk);
        release dut.ok_count;
        exp_ok = 32'hFFFF_FFFF;
        idle(1);
        check("preload_num_ok", {32'd0, num_pkts_ok}, {32'd0, exp_ok});
        send_pkt(32'hC0A8_0002, 16'hD536, 16'h0070, 8, 1'b0, 1'b0, 1'b1, 4'h0);
        check_counters("wrap");

        // Let any outstanding verdicts arrive, bounded
        for (int k = 0; k < 20 && sb_q.size() != 0; k++) @(negedge clk);
        check("scoreboard_drain", 64'(sb_q.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
